alu8_result_buffer: RTL
=======================

# alu8_result_buffer

Downstream stage of the 8-bit ALU: captures each ALU result (opcode, 8-bit result, 16-bit product, OF/zero/slt flags) into a small FIFO under a valid/ready handshake and presents them in order to the consumer (register-file write-back or host interface). It selects the meaningful datum per opcode and maintains sticky-overflow and overflow-count status for software.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH)+1, width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream presents an ALU result this cycle.
- in_ready  output  1  buffer can accept; equals !full.
- in_op  input  4  opcode the ALU executed.
- in_result  input  8  ALU result bus.
- in_product  input  16  ALU product bus (signed).
- in_of, in_zero, in_slt  input  1 each  ALU flags.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes head this cycle.
- out_op  output  4  opcode of head entry.
- out_data  output  16  selected datum of head entry.
- out_flags  output  3  {of, zero, slt} of head entry.
- out_illegal  output  1  head entry opcode is 4'b1100..4'b1111.
- count  output  CW  current occupancy, 0..DEPTH.
- sticky_of  output  1  set by any accepted entry with in_of=1.
- of_count  output  8  number of accepted entries with in_of=1, saturating.
- clr_status  input  1  synchronous clear of sticky_of and of_count.

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready. Both may occur in the same cycle.
- Data selection at push: in_op == 4'b1011 (multiply) -> stored data = in_product; in_op 4'b0000..4'b1010 -> {8'h00, in_result}; in_op >= 4'b1100 -> 16'h0000 and illegal bit = 1. Flags stored unchanged for every opcode.
- Storage: circular array of DEPTH entries {op, data[15:0], flags[2:0], illegal}; write pointer and read pointer of $clog2(DEPTH) bits wrap from DEPTH-1 to 0; count is tracked explicitly.
- count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
- Full (count == DEPTH): in_ready = 0; in_valid ignored, no data lost or overwritten; upstream must hold.
- Empty (count == 0): out_valid = 0; out_ready ignored; pointers do not move; out_* fields hold the stale head contents and have no meaning.
- sticky_of: set on a push with in_of = 1; cleared by clr_status; clr_status and setting push in the same cycle leave sticky_of = 1.
- of_count: +1 on a push with in_of = 1, saturating at 8'hFF; clr_status sets it to 0, except that a simultaneous setting push sets it to 1.
- No internal state machine beyond pointers and counter; no bypass path from in_* to out_*.

## Timing
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, in_ready = 1, out_valid = 0, out_op = 0, out_data = 0, out_flags = 0, out_illegal = 0, sticky_of = 0, of_count = 0. Storage contents are not reset and are not observable while empty.
- Reset asserted mid-operation discards all entries immediately; first push after deassertion is accepted on the first rising edge with rst_n high.
- Latency: an entry pushed at edge N has out_valid = 1 and valid out_* fields after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- in_ready and out_valid are functions of registered count only; no combinational path from out_ready to in_ready or from in_valid to out_valid.
- When full, a pop at edge N makes in_ready = 1 after edge N; a push is not accepted in the same cycle as that pop.

## Test plan
- Reset then single push op=4'b1001, result=8'h5A, flags=3'b000 -> next cycle out_valid=1, out_data=16'h005A, out_op=4'b1001, count=1; pop -> count=0, out_valid=0.
- Push op=4'b1011, product=16'hFFF4 (-3 × 4) -> out_data=16'hFFF4; push op=4'b1110 -> out_data=16'h0000, out_illegal=1.
- Push 5 entries back-to-back with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th, 5th held; count=4; drain -> entries 1-4 in order, then 5th accepted.
- Sustained simultaneous push/pop for 20 cycles starting with count=2 -> count stays 2, ordering preserved across pointer wrap.
- 300 pushes with in_of=1 -> of_count=8'hFF, sticky_of=1; clr_status alone -> both 0; clr_status with an in_of=1 push -> sticky_of=1, of_count=1.
- Assert rst_n low asynchronously with count=3 -> count=0, out_valid=0, in_ready=1 without a clock edge.

Source files
------------

// File: rtl/alu8_result_buffer.sv
// Result FIFO behind the 8-bit ALU: stores the per-opcode datum and flags of each
// accepted result, presents them in order, and keeps overflow status for software.
module alu8_result_buffer #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [7:0]    in_result,
    input  logic [15:0]   in_product,
    input  logic          in_of,
    input  logic          in_zero,
    input  logic          in_slt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [15:0]   out_data,
    output logic [2:0]    out_flags,
    output logic          out_illegal,
    output logic [CW-1:0] count,
    output logic          sticky_of,
    output logic [7:0]    of_count,
    input  logic          clr_status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 24;
    localparam logic [3:0]  OP_MUL = 4'b1011;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] head_q, head_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    ofcnt_q, ofcnt_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          push_c;
    logic          pop_c;
    logic          illegal_c;
    logic [15:0]   data_c;
    logic [EW-1:0] wr_entry_c;

    assign push_c = in_valid && in_ready_q;
    assign pop_c  = out_valid_q && out_ready;

    // Pick the meaningful datum for the opcode; reserved opcodes store zero.
    always_comb begin
        illegal_c = (in_op >= 4'b1100);
        data_c    = 16'h0000;
        if (in_op == OP_MUL) begin
            data_c = in_product;
        end else if (!illegal_c) begin
            data_c = {8'h00, in_result};
        end
        wr_entry_c = {in_op, data_c, in_of, in_zero, in_slt, illegal_c};
    end

    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d  = (count_d != CW'(DEPTH));
        out_valid_d = (count_d != CW'(0));
        // The new entry becomes head when it lands in the slot the read pointer moves to.
        head_d = (push_c && (wr_ptr_q == rd_ptr_d)) ? wr_entry_c : mem_q[rd_ptr_d];

        sticky_d = sticky_q;
        ofcnt_d  = ofcnt_q;
        if (clr_status) begin
            sticky_d = push_c && in_of;
            ofcnt_d  = (push_c && in_of) ? 8'h01 : 8'h00;
        end else if (push_c && in_of) begin
            sticky_d = 1'b1;
            if (ofcnt_q != 8'hFF) begin
                ofcnt_d = ofcnt_q + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            sticky_q    <= 1'b0;
            ofcnt_q     <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sticky_q    <= sticky_d;
            ofcnt_q     <= ofcnt_d;
            if (push_c || pop_c) begin
                head_q <= head_d;
            end
        end
    end

    // Storage is deliberately not reset; it is never observed while empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign count       = count_q;
    assign out_op      = head_q[23:20];
    assign out_data    = head_q[19:4];
    assign out_flags   = head_q[3:1];
    assign out_illegal = head_q[0];
    assign sticky_of   = sticky_q;
    assign of_count    = ofcnt_q;

endmodule
